// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy; push while full and pop while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, baud_tick paced, back-to-back frames.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd parity).
module uart_tx_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              baud_tick,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              uart_tx,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo_core: illegal parameter set");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift, fifo_rdata;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 frame_end, pop;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  // A pop only happens on a tick that starts a frame: from IDLE or at the end of the last stop bit.
  assign frame_end = (state == STOP) && (stop_cnt == STOP_LAST);
  assign pop       = baud_tick && !fifo_empty && ((state == IDLE) || frame_end);
  assign in_ready  = !fifo_full;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      uart_tx  <= LINE_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (baud_tick) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            uart_tx <= shift[0];
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              uart_tx  <= par;
`else
              state    <= STOP;
              stop_cnt <= 1'b0;
              uart_tx  <= LINE_IDLE;
`endif
            end else begin
              shift   <= shift >> 1;
              uart_tx <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            uart_tx  <= LINE_IDLE;
          end
`endif
          STOP: begin
            if (frame_end) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: ;
        endcase
        // Loading the next word overrides the IDLE fallback so frames abut.
        if (pop) begin
          state   <= START;
          shift   <= fifo_rdata;
          uart_tx <= START_BIT;
          busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
          par     <= (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Bench for uart_tx_fifo_core: an 8N1/depth-4 instance and a 5-bit/2-stop/depth-2 instance against a frame-list model.
module tb_uart_tx_fifo_core;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int L0 = 1 + 8 + PAR_EN + 1;
  localparam int L1 = 1 + 5 + PAR_EN + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] in_data0 = '0;
  logic [4:0] in_data1 = '0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic       in_ready0, in_ready1, uart_tx0, uart_tx1, busy0, busy1, done0, done1;
  logic [2:0] fifo_count0;
  logic [1:0] fifo_count1;

  always #5 clk = ~clk;

  uart_tx_fifo_core #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .uart_tx(uart_tx0), .busy(busy0), .done(done0), .fifo_count(fifo_count0));

  uart_tx_fifo_core #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .uart_tx(uart_tx1), .busy(busy1), .done(done1), .fifo_count(fifo_count1));

  int n_cmp = 0, n_bad = 0;
  int nd0 = 0, nd1 = 0;

  // Model: a queue of words per channel and the bit list of the frame on the line.
  logic [8:0]  mq [2][$];
  logic [15:0] mframe [2];
  int          mlen [2], mpos [2];
  bit          mact [2], mdone [2];

  function automatic logic [15:0] build_frame(input logic [8:0] d, input int db, input int pe, input bit odd);
    logic [15:0] f = '1;
    bit p = odd;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      p ^= d[i];
    end
    if (pe != 0) f[1+db] = p;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      mact[c] = 1'b0; mdone[c] = 1'b0; mpos[c] = 0; mlen[c] = 0;
    end
  endtask

  task automatic model_step(input int ch, input bit t, input bit v, input logic [8:0] d);
    int  db  = (ch == 0) ? 8 : 5;
    int  sb  = (ch == 0) ? 1 : 2;
    int  dep = (ch == 0) ? 4 : 2;
    bit  push = v && (mq[ch].size() < dep);
    mdone[ch] = 1'b0;
    if (t) begin
      if (mact[ch]) begin
        mpos[ch]++;
        if (mpos[ch] == mlen[ch]) begin
          mact[ch]  = 1'b0;
          mdone[ch] = 1'b1;
        end
      end
      if (!mact[ch] && mq[ch].size() != 0) begin
        mframe[ch] = build_frame(mq[ch].pop_front(), db, PAR_EN, ch == 1);
        mlen[ch]   = 1 + db + PAR_EN + sb;
        mpos[ch]   = 0;
        mact[ch]   = 1'b1;
      end
    end
    if (push) mq[ch].push_back(d);
  endtask

  task automatic compare_all();
    logic e0, e1;
    e0 = mact[0] ? mframe[0][mpos[0]] : 1'b1;
    e1 = mact[1] ? mframe[1][mpos[1]] : 1'b1;
    check("tx0", uart_tx0, e0);
    check("busy0", busy0, mact[0]);
    check("done0", done0, mdone[0]);
    check("count0", fifo_count0, mq[0].size());
    check("ready0", in_ready0, mq[0].size() < 4);
    check("tx1", uart_tx1, e1);
    check("busy1", busy1, mact[1]);
    check("done1", done1, mdone[1]);
    check("count1", fifo_count1, mq[1].size());
    check("ready1", in_ready1, mq[1].size() < 2);
    if (done0) nd0++;
    if (done1) nd1++;
  endtask

  // One clock: drive at negedge, model at posedge, compare at the following negedge.
  task automatic cyc(input bit t, input bit v0, input logic [7:0] d0, input bit v1, input logic [4:0] d1);
    baud_tick = t; in_valid0 = v0; in_data0 = d0; in_valid1 = v1; in_data1 = d1;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0, t, v0, {1'b0, d0});
      model_step(1, t, v1, {4'b0, d1});
    end
    @(negedge clk);
    baud_tick = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    compare_all();
  endtask

  task automatic tick_after(input int gap);
    repeat (gap - 1) cyc(1'b0, 1'b0, 8'h0, 1'b0, 5'h0);
    cyc(1'b1, 1'b0, 8'h0, 1'b0, 5'h0);
  endtask

  initial begin
    logic [31:0] cap0, cap1;
    logic [7:0]  w [6];
    logic [7:0]  d;
    bit          bq [$];
    int          idx, base0, base1, zeros;
    bit          acc, t;

    model_reset();
    // Model pins against hand-derived frames.
    check("pin_55_8n1",   32'(build_frame(9'h055, 8, 0, 1'b0) & 16'h03FF), 32'h2AA);
    check("pin_1f_5n1",   32'(build_frame(9'h01F, 5, 0, 1'b0) & 16'h007F), 32'h7E);
    check("pin_07_8e2",   32'(build_frame(9'h007, 8, 1, 1'b0) & 16'h0FFF), 32'hE0E);
    check("pin_1f_5o2",   32'(build_frame(9'h01F, 5, 1, 1'b1) & 16'h01FF), 32'h1BE);

    repeat (3) cyc(1'b0, 1'b0, 8'h0, 1'b0, 5'h0);
    check("rst_tx", uart_tx0, 1); check("rst_ready", in_ready0, 1);
    check("rst_busy", busy0, 0);  check("rst_done", done0, 0);
    check("rst_count", fifo_count0, 0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 8'h0, 1'b0, 5'h0);

    // Single frames on both instances, 16 clocks per bit.
    base0 = nd0; base1 = nd1; cap0 = '1; cap1 = '1;
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 5'h1F);
    for (int i = 0; i < 14; i++) begin
      tick_after(16);
      cap0[i] = uart_tx0;
      cap1[i] = uart_tx1;
    end
`ifdef UART_TX_PARITY_EN
    check("frame_55", cap0 & 32'h7FF, 32'h4AA);
    check("frame_1f", cap1 & 32'h1FF, 32'h1BE);
`else
    check("frame_55", cap0 & 32'h3FF, 32'h2AA);
    check("frame_1f", cap1 & 32'hFF, 32'hFE);
`endif
    check("done_once0", nd0 - base0, 1); check("done_once1", nd1 - base1, 1);
    check("idle_busy0", busy0, 0);       check("idle_busy1", busy1, 0);

    // Six words with in_valid held: fill to full, then stream back-to-back.
    w[0] = 8'hA1; w[1] = 8'h3C; w[2] = 8'hFF; w[3] = 8'h00; w[4] = 8'h5A; w[5] = 8'h81;
    idx = 0; base0 = nd0;
    repeat (6) begin
      acc = in_ready0;
      cyc(1'b0, 1'b1, w[idx], 1'b0, 5'h0);
      if (acc) idx++;
    end
    check("full_accepted", idx, 4);
    check("full_ready", in_ready0, 0);
    check("full_count", fifo_count0, 4);
    for (int c = 0; c < (6 * L0 + 2) * 4; c++) begin
      t = (c % 4) == 3;
      acc = in_ready0 && (idx < 6);
      cyc(t, idx < 6, w[(idx < 6) ? idx : 0], 1'b0, 5'h0);
      if (acc) idx++;
      if (t) bq.push_back(uart_tx0);
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) d[i] = bq[k * L0 + 1 + i];
      check("b2b_start", bq[k * L0], 0);
      check("b2b_byte", d, w[k]);
      check("b2b_stop", bq[k * L0 + L0 - 1], 1);
    end
    check("b2b_idle_after", bq[6 * L0], 1);
    check("b2b_done", nd0 - base0, 6);

    // Push on the same edge as a tick while idle and empty.
    cyc(1'b1, 1'b1, 8'hC6, 1'b0, 5'h0);
    check("sametick_tx", uart_tx0, 1);
    check("sametick_count", fifo_count0, 1);
    tick_after(4);
    check("nexttick_tx", uart_tx0, 0);
    check("nexttick_count", fifo_count0, 0);
    repeat (L0 + 1) tick_after(4);

    // Asynchronous reset in the middle of DATA with two words still queued.
    cyc(1'b0, 1'b1, 8'hA3, 1'b0, 5'h0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 5'h0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0, 5'h0);
    repeat (4) tick_after(4);
    check("mid_bit2", uart_tx0, 0);
    check("mid_count", fifo_count0, 2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_tx", uart_tx0, 1);   check("arst_count", fifo_count0, 0);
    check("arst_busy", busy0, 0);    check("arst_ready", in_ready0, 1);
    repeat (2) cyc(1'b0, 1'b0, 8'h0, 1'b0, 5'h0);
    rst_n = 1'b1;
    zeros = 0;
    repeat (30) begin
      tick_after(4);
      if (uart_tx0 == 1'b0) zeros++;
    end
    check("post_rst_no_frame", zeros, 0);
    check("post_rst_busy", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_core.md
# uart_tx_fifo_core

Parametrised, buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO, then serialises them LSB-first with start bit, optional parity and 1–2 stop bits, paced by an external single-cycle baud tick. Sits between the system-side producer and the `uart_tx` pin, next to the shared baud-rate generator. Sends back-to-back frames with no idle gap while the FIFO holds data.

## Interface
Parameters:
- `DATA_BITS`, 8: payload width, 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity. Used only when parity is compiled in.
- `FIFO_DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  Single clock.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `baud_tick`  in  1  One-`clk` pulse per bit period.
- `in_data`  in  DATA_BITS  Byte to send.
- `in_valid`  in  1  Producer offers `in_data`.
- `in_ready`  out  1  FIFO can accept. Equals not full.
- `uart_tx`  out  1  Serial line, registered, idles high.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  One-cycle pulse when the final stop bit of a frame ends.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  Occupancy.

## Operation
- Push happens when `in_valid && in_ready` at a `clk` edge.
- Pop happens only on a `baud_tick` when the FSM is entering START. It loads the shift register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `baud_tick` with FIFO non-empty, pop and go to START.
  - START: line is 0. On `baud_tick`, go to DATA with the bit counter at 0.
  - DATA: line is `shift[0]`. On each `baud_tick`, shift right and increment the counter. After DATA_BITS ticks, go to PARITY if compiled in, otherwise to STOP.
  - PARITY: line is the parity bit. On `baud_tick`, go to STOP.
  - STOP: line is 1. Count STOP_BITS ticks. On the last one, pulse `done`. Then pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Frame length in ticks: 1 + DATA_BITS + parity (0/1) + STOP_BITS.
- Simultaneous push and pop: occupancy is unchanged.
- Push while the FIFO is empty and a tick arrives in the same cycle: no pop that cycle. The pushed word is eligible from the next tick.
- Full FIFO: `in_ready` is 0, so no push is possible. Data is never overwritten.
- FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count tracks 0..FIFO_DEPTH.
- Reset asserted mid-frame, asynchronously:
  - `uart_tx`=1, `busy`=0, `done`=0.
  - FIFO flushed: `fifo_count`=0, `in_ready`=1.
  - FSM in IDLE.
  - The frame in progress is abandoned.

## Timing
- Reset values: `uart_tx`=1, `in_ready`=1, `busy`=0, `done`=0, `fifo_count`=0.
- `uart_tx`, `busy` and `done` update on the `clk` edge at which `baud_tick` is sampled. Each bit holds for exactly one tick interval.
- Latency: a word pushed into an empty, idle block drives the start bit on the first `baud_tick` at least one `clk` after the push.
- `in_ready` updates the cycle after a push/pop changes occupancy. `fifo_count` is registered.
- `baud_tick` outside a frame has no effect unless a pop is pending.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state present.
  - Parity bit = XOR of the data bits, XOR `PARITY_ODD`.
  - 8-bit data gives an 11- or 12-tick frame.
- Undefined:
  - PARITY state and logic absent.
  - `PARITY_ODD` ignored.
  - Frame = 1 + DATA_BITS + STOP_BITS ticks.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Line idle level constant (1).
  - Start bit level constant (0).
- Sub-module `uart_tx_fifo`: synchronous FIFO parametrised by width and depth. Provides push/pop, full/empty and count.
- Top level: FSM, shift register, bit counter and stop counter.

## Test plan
- 8N1, no parity: push 0x55, ticks every 16 clk.
  - `uart_tx` sequence: 0,1,0,1,0,1,0,1,0,1 (10 ticks).
  - One `done` pulse, then IDLE, `busy`=0.
- Macro defined, `PARITY_ODD`=0, `STOP_BITS`=2, data 0x07.
  - Frame: 0,1,1,1,0,0,0,0,0,1(parity),1,1.
  - 12 ticks.
- `FIFO_DEPTH`=4, `in_valid` held with 6 words.
  - `in_ready` drops after 4 accepted.
  - Frames run back-to-back: the stop bit is followed directly by a start bit on the next tick.
  - All 6 bytes are emitted in order.
- Push on the same cycle as `baud_tick` while idle and empty.
  - Start bit appears on the following tick, not the current one.
  - `fifo_count` goes 0→1→0.
- `rst_n` pulled low in the middle of the DATA state of 0xA3 with 2 words queued.
  - `uart_tx`=1 immediately, asynchronously.
  - `fifo_count`=0.
  - After release, no frame starts until a new push.
- `DATA_BITS`=5, push 0x1F.
  - Frame: 0,1,1,1,1,1,1.
  - 7 ticks, macro undefined.
